// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the in-order writeback stage and one
// buffered long-latency result; also tracks pending long-latency destinations for decode.
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_writeW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rd_D,
  input  logic        use_rs1_D,
  input  logic        use_rs2_D,
  input  logic        use_rd_D,
  output logic        hz_stall,
  output logic        pipe_stall,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  // Encoding is {buf_valid, pipe_stall} so both fall straight out of the state register.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StHold   = 2'b10,
    StStarve = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] sb_q, sb_d;

  logic buf_valid;
  logic ws_wr;
  logic grant;
  logic drain;

  assign buf_valid  = state_q[1];
  assign pipe_stall = state_q[0];
  assign lu_ready   = ~buf_valid;

  assign ws_wr = reg_writeW & (rdW != 5'd0);
  assign grant = buf_valid & ~ws_wr & (buf_rd_q != 5'd0);
  // A result for x0 never needs the port, so it leaves the buffer even under W-stage traffic.
  assign drain = buf_valid & (~ws_wr | (buf_rd_q == 5'd0));

  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lu_valid) begin
          state_d    = StHold;
          buf_rd_d   = lu_rd;
          buf_data_d = lu_data;
          wait_cnt_d = 8'd0;
        end
      end
      StHold: begin
        if (drain) begin
          state_d    = StIdle;
          wait_cnt_d = 8'd0;
        end else begin
          if (wait_cnt_q == WaitLast) state_d = StStarve;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StStarve: begin
        if (drain) begin
          state_d    = StIdle;
          wait_cnt_d = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scoreboard: clear on grant first so a same-cycle issue to that register wins.
  always_comb begin
    sb_d = sb_q;
    if (grant) sb_d[buf_rd_q] = 1'b0;
    if (lu_issue) sb_d[lu_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign hz_stall = (use_rs1_D & sb_q[rs1_D]) | (use_rs2_D & sb_q[rs2_D]) |
                    (use_rd_D & sb_q[rd_D]);

  always_comb begin
    wb_we   = reg_writeW;
    wb_addr = rdW;
    wb_data = resultW;
    if (grant) begin
      wb_we   = 1'b1;
      wb_addr = buf_rd_q;
      wb_data = buf_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      buf_rd_q   <= 5'd0;
      buf_data_q <= 32'd0;
      wait_cnt_q <= 8'd0;
      sb_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wait_cnt_q <= wait_cnt_d;
      sb_q       <= sb_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed plus randomized bench for wb_port_arbiter, checked against a behavioural model
// that tracks the buffered result by its age and the scoreboard as a bit array.
module tb_wb_port_arbiter;

  localparam int unsigned MW = 4;

  logic        clk;
  logic        reset;
  logic        reg_writeW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rs1_D, rs2_D, rd_D;
  logic        use_rs1_D, use_rs2_D, use_rd_D;
  logic        hz_stall;
  logic        pipe_stall;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_bv;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_age;
  bit          m_sb[32];

  wb_port_arbiter #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_writeW (reg_writeW),
    .rdW        (rdW),
    .resultW    (resultW),
    .lu_issue   (lu_issue),
    .lu_issue_rd(lu_issue_rd),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .rs1_D      (rs1_D),
    .rs2_D      (rs2_D),
    .rd_D       (rd_D),
    .use_rs1_D  (use_rs1_D),
    .use_rs2_D  (use_rs2_D),
    .use_rd_D   (use_rd_D),
    .hz_stall   (hz_stall),
    .pipe_stall (pipe_stall),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bv = 0; m_rd = '0; m_data = '0; m_age = 0;
    for (int i = 0; i < 32; i++) m_sb[i] = 0;
  endtask

  task automatic idle_inputs();
    reg_writeW = 0; rdW = '0; resultW = '0;
    lu_issue = 0; lu_issue_rd = '0; lu_valid = 0; lu_rd = '0; lu_data = '0;
    rs1_D = '0; rs2_D = '0; rd_D = '0; use_rs1_D = 0; use_rs2_D = 0; use_rd_D = 0;
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle();
    bit          ws, gw, ehz;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    #3;
    ws = reg_writeW && (rdW != 0);
    gw = m_bv && !ws && (m_rd != 0);
    if (gw) begin ewe = 1; ea = m_rd; ed = m_data; end
    else begin ewe = reg_writeW; ea = rdW; ed = resultW; end
    ehz = (use_rs1_D && m_sb[rs1_D]) || (use_rs2_D && m_sb[rs2_D]) || (use_rd_D && m_sb[rd_D]);
    chk("m_wb_we", 32'(wb_we), 32'(ewe));
    chk("m_wb_addr", 32'(wb_addr), 32'(ea));
    chk("m_wb_data", wb_data, ed);
    chk("m_lu_ready", 32'(lu_ready), 32'(!m_bv));
    chk("m_pipe_stall", 32'(pipe_stall), 32'(m_bv && m_age >= int'(MW)));
    chk("m_hz_stall", 32'(hz_stall), 32'(ehz));
  endtask

  // Clock edge: advance the model with the inputs held over the edge.
  task automatic tick();
    bit ws;
    @(posedge clk);
    ws = reg_writeW && (rdW != 0);
    if (m_bv) begin
      if (m_rd == 0 || !ws) begin
        if (m_rd != 0) m_sb[m_rd] = 0;
        m_bv = 0;
      end else begin
        m_age++;
      end
    end else if (lu_valid) begin
      m_bv = 1; m_rd = lu_rd; m_data = lu_data; m_age = 0;
    end
    if (lu_issue && lu_issue_rd != 0) m_sb[lu_issue_rd] = 1;
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 0;
    #3;
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rst_hz_stall", 32'(hz_stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1;

    // Idle port: result written the cycle after the handshake
    lu_valid = 1; lu_rd = 5'd5; lu_data = 32'hDEAD_BEEF;
    step();
    lu_valid = 0;
    settle();
    chk("idle_we", 32'(wb_we), 32'd1);
    chk("idle_addr", 32'(wb_addr), 32'd5);
    chk("idle_data", wb_data, 32'hDEAD_BEEF);
    tick();
    settle();
    chk("idle_ready", 32'(lu_ready), 32'd1);
    tick();

    // Conflict: two W-stage writes, then the buffered result
    lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h0000_0077;
    step();
    lu_valid = 0; reg_writeW = 1; rdW = 5'd3; resultW = 32'h11;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("conf_addr_w", 32'(wb_addr), 32'd3);
      tick();
    end
    reg_writeW = 0;
    settle();
    chk("conf_addr_lu", 32'(wb_addr), 32'd7);
    chk("conf_we_lu", 32'(wb_we), 32'd1);
    chk("conf_no_stall", 32'(pipe_stall), 32'd0);
    tick();
    step();

    // Starvation
    lu_valid = 1; lu_rd = 5'd12; lu_data = 32'hCAFE_0012;
    reg_writeW = 1; rdW = 5'd4; resultW = 32'h44;
    step();
    lu_valid = 0;
    for (int i = 0; i < int'(MW) - 1; i++) step();
    settle();
    chk("starve_not_yet", 32'(pipe_stall), 32'd0);
    tick();
    settle();
    chk("starve_rise", 32'(pipe_stall), 32'd1);
    tick();
    step();
    reg_writeW = 0;
    settle();
    chk("starve_grant_addr", 32'(wb_addr), 32'd12);
    chk("starve_grant_data", wb_data, 32'hCAFE_0012);
    tick();
    settle();
    chk("starve_fall", 32'(pipe_stall), 32'd0);
    tick();

    // Scoreboard
    lu_issue = 1; lu_issue_rd = 5'd9;
    step();
    lu_issue = 0; rs2_D = 5'd9; use_rs2_D = 1;
    settle();
    chk("sb_hit", 32'(hz_stall), 32'd1);
    tick();
    lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h99;
    step();
    lu_valid = 0;
    step();
    settle();
    chk("sb_cleared", 32'(hz_stall), 32'd0);
    tick();
    lu_valid = 1;
    step();
    lu_valid = 0; lu_issue = 1; lu_issue_rd = 5'd9;
    step();
    lu_issue = 0;
    settle();
    chk("sb_set_wins", 32'(hz_stall), 32'd1);
    tick();
    lu_valid = 1;
    step();
    lu_valid = 0;
    step();
    step();

    // x0 handling
    lu_issue = 1; lu_issue_rd = 5'd0; rs1_D = 5'd0; use_rs1_D = 1;
    step();
    lu_issue = 0;
    settle();
    chk("x0_issue", 32'(hz_stall), 32'd0);
    tick();
    lu_valid = 1; lu_rd = 5'd0; lu_data = 32'hBAD0_BAD0;
    step();
    lu_valid = 0;
    settle();
    chk("x0_no_write", 32'(wb_we), 32'd0);
    tick();
    settle();
    chk("x0_buf_clear", 32'(lu_ready), 32'd1);
    tick();

    // Async reset while starving
    lu_issue = 1; lu_issue_rd = 5'd20;
    step();
    lu_issue = 0; lu_valid = 1; lu_rd = 5'd20; lu_data = 32'h2020;
    reg_writeW = 1; rdW = 5'd1; resultW = 32'h1;
    step();
    lu_valid = 0; rs1_D = 5'd20; use_rs1_D = 1;
    for (int i = 0; i < int'(MW); i++) step();
    settle();
    chk("ar_in_starve", 32'(pipe_stall), 32'd1);
    #1;
    reset = 0;
    #1;
    model_reset();
    chk("ar_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("ar_lu_ready", 32'(lu_ready), 32'd1);
    chk("ar_hz_stall", 32'(hz_stall), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      reg_writeW = ($urandom_range(0, 99) < 55);
      rdW = 5'($urandom_range(0, 31));
      resultW = $urandom;
      lu_valid = ($urandom_range(0, 99) < 50);
      lu_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lu_data = $urandom;
      r = 5'($urandom_range(0, 31));
      lu_issue = ($urandom_range(0, 99) < 30) && !m_sb[r];
      lu_issue_rd = r;
      rs1_D = 5'($urandom_range(0, 31));
      rs2_D = 5'($urandom_range(0, 31));
      rd_D = 5'($urandom_range(0, 31));
      use_rs1_D = 1'($urandom_range(0, 1));
      use_rs2_D = 1'($urandom_range(0, 1));
      use_rd_D = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
